commit_trace_buffer: RTL
========================

Name: commit_trace_buffer

Overview:
- Synthesizable on-chip trace recorder for the single-cycle MIPS core; replaces per-cycle dumping of pc/instr from the bench.
- Captures one entry (pc, inst) per retired instruction into a parametrised circular buffer.
- Supports a PC-match trigger with post-trigger window, wrap or stop-when-full modes, and a valid/ready readout port for the bench or a debug UART.

Parameters:
- PC_W, 32, width of captured PC
- INST_W, 32, width of captured instruction
- DEPTH, 64, entries; power of two, >=4
- POST_TRIG, 16, commits captured after trigger entry; 0 allowed

Ports:
- clk_in  in  1  clock (single domain)
- reset  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle pulse; clears buffer and starts capture
- cfg_wrap  in  1  1 = circular overwrite, 0 = stop when full; sampled on arm
- trig_pc_en  in  1  enable PC-match trigger; sampled on arm
- trig_pc  in  PC_W  trigger PC; sampled on arm
- cm_valid  in  1  instruction retired this cycle
- cm_pc  in  PC_W  retired PC
- cm_inst  in  INST_W  retired instruction
- rd_valid  out  1  readout entry available
- rd_ready  in  1  consumer accepts entry
- rd_pc  out  PC_W  readout PC
- rd_inst  out  INST_W  readout instruction
- count  out  $clog2(DEPTH)+1  valid entries held
- state  out  2  0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
- overflow  out  1  sticky; oldest entries were overwritten
- done  out  1  high in DONE

Behaviour:
- Reset (async, any state): state=IDLE; wr_ptr=rd_ptr=0; count=0; overflow=0; done=0; rd_valid=0; rd_pc=rd_inst=0; post counter=0. Array contents are not cleared.
- arm, any state: next state CAPTURE; pointers, count and overflow cleared; cfg_wrap, trig_pc_en and trig_pc latched. A cm_valid in the same cycle is discarded.
- IDLE: commits are ignored.
- CAPTURE, on cm_valid:
  - Write entry at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH.
  - count increments, saturating at DEPTH.
  - Full with latched wrap=1: overwrite the oldest entry; overflow set (sticky).
  - Write makes count==DEPTH with wrap=0: next state DONE.
  - Trigger: latched trig_pc_en && cm_pc==trig_pc. Trigger entry is written; post counter = POST_TRIG; next state POST, or DONE if POST_TRIG==0.
  - Trigger and full/no-wrap in the same cycle: DONE.
  - trig_pc_en=0 with wrap=1: capture continues until the next arm.
- POST, on cm_valid:
  - Write as in CAPTURE; decrement post counter; on reaching 0, next state DONE.
  - Full with wrap=0 also forces DONE.
  - PC matches in POST do not retrigger.
- DONE:
  - done=1; commits ignored.
  - Oldest entry is at wr_ptr if overflow=1, else 0; rd_ptr is loaded with it on entry to DONE.
  - rd_valid = (count!=0). rd_pc/rd_inst show entry[rd_ptr] and stay stable while rd_valid && !rd_ready.
  - On rd_valid && rd_ready: rd_ptr advances mod DEPTH, count decrements, next entry is presented the following cycle. Throughput is 1 entry/cycle.
  - count==0: rd_valid=0; state stays DONE until arm.
- State transitions are registered; done and state update one cycle after the causing commit.
- rd_valid is 0 outside DONE.

Optional Feature:
- Macro TRACE_REGWB_EN. When defined:
  - Extra inputs cm_rf_we(1), cm_rf_waddr(5), cm_rf_wdata(32).
  - Matching outputs rd_rf_we, rd_rf_waddr, rd_rf_wdata are stored per entry and follow the same readout rules; reset value 0.
- When undefined, these ports and storage are absent and behaviour is otherwise identical.

Test Plan (DEPTH=8, POST_TRIG=2):
- Stop mode: arm with wrap=0, trig off; 10 commits pc=0x00400000+4k -> DONE after the 8th commit, count=8, overflow=0. Readout with rd_ready=1 yields pc 0x00400000..0x0040001C in order, back-to-back, then rd_valid=0.
- Wrap mode: arm with wrap=1, trig on at pc=0x00400030; commits k=0..14 -> trigger at k=12, DONE after k=14. overflow=1, count=8, readout pc 0x0040001C..0x00400038.
- Backpressure: in DONE, hold rd_ready=0 for 5 cycles -> rd_pc held at the first entry, count unchanged. Alternating rd_ready -> no entry lost or duplicated.
- Arm collision: arm with cm_valid in the same cycle -> that commit is not stored, count=0. Re-arm mid-POST -> state=CAPTURE, count=0, overflow=0.
- Reset mid-capture: assert reset asynchronously between clock edges after 3 commits -> state=IDLE, count=0, rd_valid=0 immediately; commits after release are ignored until arm.
- TRACE_REGWB_EN build: commit with rf_we=1, waddr=5'd8, wdata=0xDEADBEEF -> the same values appear on the rd_rf_* outputs at readout.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit trace recorder: captures (pc, inst) per retired instruction into a circular buffer with
// PC trigger, post-trigger window and valid/ready readout. Define TRACE_REGWB_EN to record writeback.
module commit_trace_buffer #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned INST_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned POST_TRIG = 16
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    cfg_wrap,
  input  logic                    trig_pc_en,
  input  logic [PC_W-1:0]         trig_pc,
  input  logic                    cm_valid,
  input  logic [PC_W-1:0]         cm_pc,
  input  logic [INST_W-1:0]       cm_inst,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [PC_W-1:0]         rd_pc,
  output logic [INST_W-1:0]       rd_inst,
  output logic [$clog2(DEPTH):0]  count,
  output logic [1:0]              state,
  output logic                    overflow,
  output logic                    done
`ifdef TRACE_REGWB_EN
  ,
  input  logic                    cm_rf_we,
  input  logic [4:0]              cm_rf_waddr,
  input  logic [31:0]             cm_rf_wdata,
  output logic                    rd_rf_we,
  output logic [4:0]              rd_rf_waddr,
  output logic [31:0]             rd_rf_wdata
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StPost    = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_nx;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   post_q;
  logic            overflow_q, wrap_q, trig_en_q;
  logic [PC_W-1:0] trig_pc_q;

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];

  logic wr_en, full, stop_full, hit, post_end, go_done, ovf_nx;

  always_comb begin
    wr_en     = cm_valid && !arm && (state_q == StCapture || state_q == StPost);
    wr_ptr_nx = wr_ptr_q + 1'b1;
    full      = (count_q == CW'(DEPTH));
    stop_full = !wrap_q && (count_q == CW'(DEPTH - 1));
    ovf_nx    = overflow_q | (full & wrap_q);
    hit       = (state_q == StCapture) && trig_en_q && (cm_pc == trig_pc_q);
    post_end  = (state_q == StPost) && (post_q == PW'(1));
    go_done   = stop_full || post_end || (hit && (POST_TRIG == 0));
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_pc[wr_ptr_q]   <= cm_pc;
      mem_inst[wr_ptr_q] <= cm_inst;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      overflow_q <= 1'b0;
      wrap_q     <= 1'b0;
      trig_en_q  <= 1'b0;
      trig_pc_q  <= '0;
    end else if (arm) begin
      // A commit coinciding with arm is dropped.
      state_q    <= StCapture;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      overflow_q <= 1'b0;
      wrap_q     <= cfg_wrap;
      trig_en_q  <= trig_pc_en;
      trig_pc_q  <= trig_pc;
    end else begin
      case (state_q)
        StCapture, StPost: begin
          if (cm_valid) begin
            wr_ptr_q   <= wr_ptr_nx;
            overflow_q <= ovf_nx;
            if (!full) count_q <= count_q + 1'b1;
            if (state_q == StPost) post_q <= post_q - 1'b1;
            if (go_done) begin
              state_q  <= StDone;
              // Oldest entry sits at the post-write pointer once anything was overwritten.
              rd_ptr_q <= ovf_nx ? wr_ptr_nx : '0;
            end else if (hit) begin
              state_q <= StPost;
              post_q  <= PW'(POST_TRIG);
            end
          end
        end
        StDone: begin
          if (rd_valid && rd_ready) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_valid = (state_q == StDone) && (count_q != '0);
    rd_pc    = rd_valid ? mem_pc[rd_ptr_q] : '0;
    rd_inst  = rd_valid ? mem_inst[rd_ptr_q] : '0;
    count    = count_q;
    state    = state_q;
    overflow = overflow_q;
    done     = (state_q == StDone);
  end

`ifdef TRACE_REGWB_EN
  logic        mem_we [DEPTH];
  logic [4:0]  mem_wa [DEPTH];
  logic [31:0] mem_wd [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_we[wr_ptr_q] <= cm_rf_we;
      mem_wa[wr_ptr_q] <= cm_rf_waddr;
      mem_wd[wr_ptr_q] <= cm_rf_wdata;
    end
  end

  always_comb begin
    rd_rf_we    = rd_valid ? mem_we[rd_ptr_q] : 1'b0;
    rd_rf_waddr = rd_valid ? mem_wa[rd_ptr_q] : '0;
    rd_rf_wdata = rd_valid ? mem_wd[rd_ptr_q] : '0;
  end
`endif

endmodule
